// File: rtl/ising_field_engine_if.sv
// Coefficient-load and compute-handshake bundle for the Ising local-field engine.
interface ising_field_engine_if #(
  parameter int N        = 4,
  parameter int DATABITS = 16,
  parameter int ACCBITS  = 20
);
  localparam int AW = (N > 1) ? $clog2(N * N) : 1;

  logic                    coef_we;
  logic [AW-1:0]           coef_addr;
  logic [DATABITS-1:0]     coef_wdata;
  logic                    start;
  logic [N-1:0]            spins;
  logic                    spin_mode;
  logic                    busy;
  logic                    done;
  logic [N*ACCBITS-1:0]    field_out;

  modport master (
    output coef_we, coef_addr, coef_wdata, start, spins, spin_mode,
    input  busy, done, field_out
  );

  modport slave (
    input  coef_we, coef_addr, coef_wdata, start, spins, spin_mode,
    output busy, done, field_out
  );
endinterface

// File: rtl/ising_field_engine.sv
// Local field h_i = sum_j J_ij * t(s_j) over a writable signed coupling store,
// LANES products per cycle, result published atomically with a done pulse.
module ising_field_engine #(
  parameter int N        = 4,
  parameter int LANES    = 2,
  parameter int DATABITS = 16,
  parameter int ACCBITS  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  ising_field_engine_if.slave  bus
);
  localparam int AW     = (N > 1) ? $clog2(N * N) : 1;
  localparam int RW     = (N > 1) ? $clog2(N) : 1;
  localparam int CHUNKS = N / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_PUB} state_e;

  state_e                      state_q, state_d;
  logic [RW-1:0]               row_q, row_d;
  logic [CW-1:0]               chunk_q, chunk_d;
  logic signed [ACCBITS-1:0]   acc_q, acc_d;
  logic signed [ACCBITS-1:0]   shadow_q [N];
  logic signed [ACCBITS-1:0]   shadow_d [N];
  logic signed [DATABITS-1:0]  coef_q [N*N];
  logic signed [DATABITS-1:0]  coef_d [N*N];
  logic [N*ACCBITS-1:0]        field_q, field_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        mode_q, mode_d;
  logic [N-1:0]                spins_q, spins_d;
  logic                        ovr_valid_q, ovr_valid_d;
  logic [AW-1:0]               ovr_addr_q, ovr_addr_d;
  logic signed [DATABITS-1:0]  ovr_data_q, ovr_data_d;

  logic                        wr_ok;
  logic signed [ACCBITS-1:0]   lane_sum;
  int unsigned                 lane_col;
  logic [AW-1:0]               lane_addr;
  logic signed [DATABITS-1:0]  lane_j;
  logic signed [ACCBITS-1:0]   lane_jx;

  assign wr_ok = bus.coef_we && !busy_q && (32'(bus.coef_addr) < N * N);

  // A write coinciding with start lands immediately; the computation keeps
  // seeing the overwritten coefficient through the override register.
  always_comb begin
    lane_sum  = '0;
    lane_col  = 0;
    lane_addr = '0;
    lane_j    = '0;
    lane_jx   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_col  = 32'(chunk_q) * LANES + l;
      lane_addr = AW'(32'(row_q) * N + lane_col);
      lane_j    = (ovr_valid_q && lane_addr == ovr_addr_q) ? ovr_data_q : coef_q[lane_addr];
      lane_jx   = ACCBITS'(lane_j);
      if (spins_q[RW'(lane_col)]) lane_sum = lane_sum + lane_jx;
      else if (mode_q)            lane_sum = lane_sum - lane_jx;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    chunk_d     = chunk_q;
    acc_d       = acc_q;
    shadow_d    = shadow_q;
    field_d     = field_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mode_d      = mode_q;
    spins_d     = spins_q;
    ovr_valid_d = ovr_valid_q;
    ovr_addr_d  = ovr_addr_q;
    ovr_data_d  = ovr_data_q;
    coef_d      = coef_q;
    if (wr_ok) coef_d[bus.coef_addr] = $signed(bus.coef_wdata);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          spins_d     = bus.spins;
          mode_d      = bus.spin_mode;
          acc_d       = '0;
          row_d       = '0;
          chunk_d     = '0;
          busy_d      = 1'b1;
          ovr_valid_d = wr_ok;
          ovr_addr_d  = bus.coef_addr;
          ovr_data_d  = coef_q[bus.coef_addr];
          state_d     = S_ACC;
        end
      end
      S_ACC: begin
        if (chunk_q == CW'(CHUNKS - 1)) begin
          shadow_d[row_q] = acc_q + lane_sum;
          acc_d           = '0;
          chunk_d         = '0;
          if (row_q == RW'(N - 1)) state_d = S_PUB;
          else                     row_d   = row_q + RW'(1);
        end else begin
          acc_d   = acc_q + lane_sum;
          chunk_d = chunk_q + CW'(1);
        end
      end
      S_PUB: begin
        for (int unsigned i = 0; i < N; i++) field_d[i*ACCBITS +: ACCBITS] = shadow_q[i];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      chunk_q     <= '0;
      acc_q       <= '0;
      field_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= 1'b0;
      spins_q     <= '0;
      ovr_valid_q <= 1'b0;
      ovr_addr_q  <= '0;
      ovr_data_q  <= '0;
      for (int unsigned i = 0; i < N; i++)     shadow_q[i] <= '0;
      for (int unsigned i = 0; i < N * N; i++) coef_q[i]   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      chunk_q     <= chunk_d;
      acc_q       <= acc_d;
      field_q     <= field_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      spins_q     <= spins_d;
      ovr_valid_q <= ovr_valid_d;
      ovr_addr_q  <= ovr_addr_d;
      ovr_data_q  <= ovr_data_d;
      shadow_q    <= shadow_d;
      coef_q      <= coef_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.field_out = field_q;
endmodule

// File: tb/tb_ising_field_engine.sv
// Randomised and directed checks of ising_field_engine against an integer
// reference of the local-field sum kept in the bench.
module tb_ising_field_engine;
  localparam int N        = 4;
  localparam int LANES    = 2;
  localparam int DATABITS = 16;
  localparam int ACCBITS  = 20;
  localparam int AW       = $clog2(N * N);
  localparam int LATENCY  = N * N / LANES + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ising_field_engine_if #(.N(N), .DATABITS(DATABITS), .ACCBITS(ACCBITS)) bus ();

  ising_field_engine #(
    .N(N), .LANES(LANES), .DATABITS(DATABITS), .ACCBITS(ACCBITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int jm [N*N];
  int exp_field [N];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int field_slice(input int i);
    logic signed [ACCBITS-1:0] v;
    v = bus.field_out[i*ACCBITS +: ACCBITS];
    return int'(v);
  endfunction

  function automatic int ref_h(input int i, input logic [N-1:0] s, input logic m);
    int sum;
    sum = 0;
    for (int j = 0; j < N; j++) begin
      if (s[j])   sum += jm[i*N + j];
      else if (m) sum -= jm[i*N + j];
    end
    return sum;
  endfunction

  task automatic check_fields(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s h%0d", tag, i), field_slice(i), exp_field[i]);
  endtask

  task automatic write_coef(input int addr, input int data);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(addr);
    bus.coef_wdata = DATABITS'(data);
    tick();
    bus.coef_we = 1'b0;
    if (addr < N * N) jm[addr] = data;
  endtask

  task automatic load_j_pattern();
    for (int a = 0; a < N * N; a++) write_coef(a, a + 1);
  endtask

  task automatic load_j_const(input int v);
    for (int a = 0; a < N * N; a++) write_coef(a, v);
  endtask

  task automatic load_j_random();
    for (int a = 0; a < N * N; a++) write_coef(a, int'($urandom_range(0, 65535)) - 32768);
  endtask

  task automatic run(input string tag, input logic [N-1:0] s, input logic m,
                     input bit disturb, input bit wr, input int wa, input int wd);
    int nxt [N];
    int k;
    for (int i = 0; i < N; i++) nxt[i] = ref_h(i, s, m);
    bus.spins     = s;
    bus.spin_mode = m;
    bus.start     = 1'b1;
    if (wr) begin
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AW'(wa);
      bus.coef_wdata = DATABITS'(wd);
    end
    tick();
    bus.start   = 1'b0;
    bus.coef_we = 1'b0;
    if (wr && wa < N * N) jm[wa] = wd;
    k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      check($sformatf("%s busy@%0d", tag, k), int'(bus.busy), 1);
      if (k == 4) check_fields($sformatf("%s hold", tag));
      if (disturb && k == 3) begin
        bus.start      = 1'b1;
        bus.coef_we    = 1'b1;
        bus.coef_addr  = '0;
        bus.coef_wdata = 16'd100;
        bus.spins      = ~s;
        bus.spin_mode  = ~m;
      end
      if (disturb && k == 4) begin
        bus.start   = 1'b0;
        bus.coef_we = 1'b0;
      end
      tick();
      k++;
    end
    check($sformatf("%s latency", tag), k, LATENCY);
    check($sformatf("%s busy@done", tag), int'(bus.busy), 0);
    for (int i = 0; i < N; i++) exp_field[i] = nxt[i];
    check_fields(tag);
  endtask

  initial begin
    int saw_done;
    logic [N-1:0] rs;
    int wa;
    for (int a = 0; a < N * N; a++) jm[a] = 0;
    for (int i = 0; i < N; i++) exp_field[i] = 0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
    bus.spins = '0; bus.spin_mode = 1'b0;

    rst = 1'b1; bus.start = 1'b1;
    tick(); tick();
    rst = 1'b0; bus.start = 1'b0;
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    check_fields("rst");
    tick();
    check("rst no start", int'(bus.busy), 0);

    load_j_pattern();
    run("p0101m0", 4'b0101, 1'b0, 0, 0, 0, 0);
    check("tp h0=4", field_slice(0), 4);
    check("tp h3=28", field_slice(3), 28);
    run("p0101m1", 4'b0101, 1'b1, 0, 0, 0, 0);
    check("tp h2=-2", field_slice(2), -2);
    run("p1111m1", 4'b1111, 1'b1, 0, 0, 0, 0);
    check("tp h3=58", field_slice(3), 58);

    run("disturb", 4'b0011, 1'b0, 1, 0, 0, 0);
    run("after disturb", 4'b0011, 1'b0, 0, 0, 0, 0);

    load_j_const(-32768);
    run("min m0", 4'b1111, 1'b0, 0, 0, 0, 0);
    check("tp min", field_slice(1), -131072);
    run("min m1", 4'b0000, 1'b1, 0, 0, 0, 0);
    check("tp max", field_slice(1), 131072);

    load_j_pattern();
    run("wr+start", 4'b1111, 1'b0, 0, 1, 5, 1234);
    run("post write", 4'b1111, 1'b0, 0, 0, 0, 0);

    for (int it = 0; it < 4; it++) begin
      load_j_random();
      for (int r = 0; r < 3; r++) begin
        rs = N'($urandom);
        wa = int'($urandom_range(0, N * N - 1));
        run($sformatf("rand%0d.%0d", it, r), rs, 1'($urandom), 0, (r == 1),
            wa, int'($urandom_range(0, 65535)) - 32768);
      end
    end

    bus.spins = 4'b1111; bus.spin_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < N * N; a++) jm[a] = 0;
    for (int i = 0; i < N; i++) exp_field[i] = 0;
    check("abort busy", int'(bus.busy), 0);
    check_fields("abort");
    saw_done = int'(bus.done);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done === 1'b1) saw_done = 1;
    end
    check("abort no done", saw_done, 0);
    run("after abort zeroJ", 4'b1010, 1'b1, 0, 0, 0, 0);
    load_j_pattern();
    run("after abort", 4'b0110, 1'b1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ising_field_engine.md
Name: ising_field_engine

Overview:
- Parametrised, handshaked successor to the serial Ising matrix-vector loop.
- Computes the local field vector h_i = sum_j J_ij * t(s_j) for an N-spin system.
- The coupling matrix J is held in a writable, signed coefficient store.
- Processes LANES products per cycle.
- Spin encoding is selectable at run time: {0,1} or {-1,+1}.
- The result is published atomically with a one-cycle done pulse.
- Feeds the spin-update / sampler stage.

Parameters:
- N, 4: number of spins; matrix is N x N.
- LANES, 2: products summed per cycle; N must be an integer multiple of LANES.
- DATABITS, 16: signed two's-complement coefficient width.
- ACCBITS, 20: signed accumulator and output width per row; must be >= DATABITS + clog2(N) + 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(N*N)  coefficient address = row*N + col.
- coef_wdata  in  DATABITS  signed J value.
- start  in  1  request a field computation.
- spins  in  N  spin vector; bit j is s_j.
- spin_mode  in  1  0: s in {0,1}; 1: bit 1 = +1, bit 0 = -1.
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse when field_out is updated.
- field_out  out  N*ACCBITS  signed h_i at [i*ACCBITS +: ACCBITS].

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: busy=0, done=0, field_out=0, all coefficients=0, FSM to IDLE. Reset has priority over every other input and aborts a computation in progress; no done is produced for an aborted computation.
- Coefficient writes:
  - Accepted only while busy=0; take effect at the clock edge.
  - Ignored while busy=1. No error flag.
  - Addresses >= N*N are ignored.
- Simultaneous write and start in IDLE: the write takes effect, but the computation uses the pre-write J value for that address.
- FSM states:
  - IDLE: on start=1, latch spins and spin_mode into internal registers, clear the row accumulator, set row=0 and chunk=0, busy=1, go to ACC.
  - ACC: each cycle, add the LANES terms for (row, chunk*LANES .. chunk*LANES+LANES-1) to the accumulator. At the last chunk, store the completed row sum into a shadow register, clear the accumulator, and advance row. After the last chunk of row N-1, go to PUB.
  - PUB: copy the shadow registers to field_out, pulse done=1, set busy=0, return to IDLE.
- Term rule:
  - spin_mode=0: term = s_j ? J_ij : 0.
  - spin_mode=1: term = s_j ? J_ij : -J_ij.
  - J is sign-extended to ACCBITS before negation or summing.
  - -(-2^(DATABITS-1)) is representable because ACCBITS > DATABITS.
- Wrap: arithmetic wraps modulo 2^ACCBITS with no saturation. The parameter rule guarantees no overflow.
- Latency:
  - Let start be sampled at edge E0.
  - ACC occupies N*N/LANES cycles.
  - done is high in exactly the cycle after edge E0 + N*N/LANES + 1. With the defaults, that is the cycle following edge E0+9.
  - busy is high from the cycle after E0 through the last ACC cycle, and low in the done cycle.
- Start while busy: ignored, not queued.
- Start in the done cycle: accepted, since the FSM is in IDLE at that edge.
- field_out stability: holds the previous result throughout a computation and changes only in the done cycle.
- Input stability: spins and spin_mode changes while busy have no effect.
- Back-to-back: start may be held high continuously, giving one computation per N*N/LANES + 2 cycles.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 -> field_out=0, busy=0, done=0; no computation starts.
- Load J_ij = 4i+j+1 (values 1..16); start with spins=4'b0101, spin_mode=0 -> done exactly 9 cycles after the start edge. Required h = {28,20,12,4}, with h0=4 in the low slice.
- Same J, spins=4'b0101, spin_mode=1 -> h0..h3 all = -2. Repeat with spins=4'b1111 -> h = {58,42,26,10}.
- Set all J = -32768 (16'h8000), spins=4'b1111, spin_mode=0 -> each h = -131072. Then spin_mode=1 with spins=4'b0000 -> each h = +131072.
- While busy:
  - Pulse start again -> ignored.
  - Write coef_addr=0 to 100 -> ignored.
  - Toggle spins -> no effect.
  - field_out holds the old value until done. After done, a new start reflects the unchanged J.
- Assert rst mid-ACC (cycle 4) -> next cycle busy=0, field_out=0, no done pulse. A subsequent start with reloaded J yields correct results.
